// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC, drives a combinational instruction memory and buffers
// fetched {pc, inst} pairs in a DEPTH-entry circular queue. A downstream
// redirect flushes the queue and restarts fetch at the (word-aligned) target.
//
// Output handshake (valid/ready): an entry transfers on a rising edge where
// out_valid=1 and out_ready=1 (and no redirect). While out_valid=1 and
// out_ready=0 the out_* fields hold steady until the transfer, a redirect or
// Reset. out_ready with out_valid=0 is ignored. out_* read 0 when empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       fetch_en,
    output logic [63:0]                imem_addr,
    output logic                       imem_req,
    input  logic [31:0]                imem_data,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [63:0]                out_pc,
    output logic [63:0]                out_pc4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Architectural state
    logic [63:0]   fpc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    // Entry storage; deliberately not reset, output gating hides stale data
    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    // Transfer qualifiers
    logic          pop;
    logic          push;
    logic          not_full;
    logic [63:0]   head_pc;
    logic [31:0]   head_inst;

    // Pop/push decisions; a full queue that is popping this cycle can still
    // accept a new fetch, which keeps throughput at one per cycle.
    always_comb begin
        not_full  = (count_q != FULL_COUNT);
        pop       = out_valid & out_ready & ~redirect;
        push      = fetch_en & ~redirect & (not_full | pop);
    end

    // Head entry read and output gating
    always_comb begin
        head_pc   = pc_mem[rd_ptr];
        head_inst = inst_mem[rd_ptr];
        out_valid = (count_q != '0);
        out_pc    = out_valid ? head_pc : 64'd0;
        out_pc4   = out_valid ? (head_pc + 64'd4) : 64'd0;
        out_inst  = out_valid ? head_inst : 32'd0;
        imem_addr = fpc;
        imem_req  = push;
        count     = count_q;
    end

    // Pointer, occupancy and fetch-PC update; redirect overrides push/pop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fpc     <= 64'd0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            fpc     <= {redirect_pc[63:2], 2'b00};
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fpc    <= fpc + 64'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry write on push; pointer wrap is free because DEPTH is a power of two
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fpc;
            inst_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, checked against
// a queue-based reference model of the fetch front end.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic          Clk;
    logic          Reset;
    logic          fetch_en;
    logic [63:0]   imem_addr;
    logic          imem_req;
    logic [31:0]   imem_data;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [63:0]   out_pc;
    logic [63:0]   out_pc4;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    // Reference model: queued {pc, inst} entries and the fetch PC
    logic [95:0] exp_q[$];
    logic [63:0] model_fpc;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .count       (count)
    );

    // Clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Combinational instruction memory: a scrambled function of the address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = a[33:2] * 32'h9E37_79B1;
        return w ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the model
    task automatic check_outputs();
        logic [95:0] head;
        int n;
        n = exp_q.size();
        check("count", 64'(count), 64'(n));
        check("out_valid", 64'(out_valid), 64'(n != 0));
        check("imem_addr", imem_addr, model_fpc);
        if (n != 0) begin
            head = exp_q[0];
            check("out_pc", out_pc, head[95:32]);
            check("out_pc4", out_pc4, head[95:32] + 64'd4);
            check("out_inst", 64'(out_inst), 64'(head[31:0]));
        end else begin
            check("out_pc_empty", out_pc, 64'd0);
            check("out_pc4_empty", out_pc4, 64'd0);
            check("out_inst_empty", 64'(out_inst), 64'd0);
        end
    endtask

    // One clock cycle: drive at negedge, check request, model the edge, check outputs
    task automatic cycle(input logic fe, input logic rdy, input logic rd, input logic [63:0] rpc);
        logic do_pop;
        logic do_push;
        fetch_en    = fe;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        do_pop  = !rd && rdy && (exp_q.size() != 0);
        do_push = !rd && fe && ((exp_q.size() < DEPTH) || do_pop);
        check("imem_req", 64'(imem_req), 64'(do_push));
        @(posedge Clk);
        if (rd) begin
            exp_q.delete();
            model_fpc = rpc & ~64'h3;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({model_fpc, mem_word(model_fpc)});
                model_fpc = model_fpc + 64'd4;
            end
        end
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_fpc = 64'd0;
    endtask

    initial begin
        Reset       = 1'b1;
        fetch_en    = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check_outputs();
        Reset = 1'b0;

        // Streaming: one instruction per cycle, count stays at 1
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 64'd0);
        check("stream_pc", out_pc, 64'h10);

        // Fill and stall
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 64'd0);
        check("stall_count", 64'(count), 64'd4);
        // Full with simultaneous pop, then drain in order
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'd0);

        // Redirect to 0x43 with three entries queued
        cycle(1'b0, 1'b1, 1'b1, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 64'd0);
        check("pre_redirect_count", 64'(count), 64'd3);
        cycle(1'b1, 1'b1, 1'b1, 64'h43);
        check("redirect_flush", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 64'd0);
        check("redirect_target", out_pc, 64'h40);
        check("redirect_pc4", out_pc4, 64'h44);

        // PC wrap at the top of the address space
        cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 64'd0);
        check("wrap_pc", out_pc, 64'h4);

        // Reset mid-stream with two entries queued
        cycle(1'b1, 1'b1, 1'b1, 64'h200);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 64'd0);
        check("pre_reset_count", 64'(count), 64'd2);
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("reset_imem_req", 64'(imem_req), 64'd1);
        @(negedge Clk);
        check_outputs();
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        fe;
            logic        rdy;
            logic        rd;
            logic [63:0] rpc;
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 99) < 7);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle(fe, rdy, rd, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that sits directly upstream of the decode/execute datapath. It owns the fetch PC, drives the combinational instruction memory, and buffers fetched instructions with their PCs in a small FIFO. Instructions go downstream over a valid/ready handshake. A downstream branch or jump redirect flushes the queue and restarts fetch at the target, so the datapath can stall or redirect without losing or duplicating instructions.

## Interface
- DEPTH, 4, number of queue entries; must be a power of two and at least 2.
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately.
- fetch_en  input  1  fetch enable; when 0, no new fetches and the fetch PC holds.
- imem_addr  output  64  fetch address to the instruction memory; equals the fetch PC (fpc).
- imem_req  output  1  a fetch is taken this cycle (combinational).
- imem_data  input  32  instruction word at imem_addr, valid in the same cycle (combinational memory).
- redirect  input  1  flush request from downstream (taken branch or jump).
- redirect_pc  input  64  restart address; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  the head entry is valid.
- out_ready  input  1  downstream accepts the head entry this cycle.
- out_inst  output  32  head instruction; 0 when out_valid=0.
- out_pc  output  64  head PC; 0 when out_valid=0.
- out_pc4  output  64  out_pc+4 (mod 2^64); 0 when out_valid=0.
- count  output  $clog2(DEPTH)+1  number of valid entries, range 0..DEPTH.

## Operation
- State:
  - fpc (64 bits).
  - DEPTH-entry storage of {pc[63:0], inst[31:0]}.
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count.
- Pop: pop = out_valid & out_ready & ~redirect.
- Push: push = fetch_en & ~redirect & (count<DEPTH | pop). A full queue with a simultaneous pop still pushes.
- imem_req = push.
- On push:
  - entry[wr_ptr] <= {fpc, imem_data}.
  - wr_ptr advances.
  - fpc <= fpc+4, wrapping modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC goes to 0).
- On pop: rd_ptr advances.
- count update: count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over everything:
  - rd_ptr, wr_ptr and count are cleared.
  - fpc <= {redirect_pc[63:2], 2'b00}.
  - No push or pop occurs in that cycle; any head offered in that cycle is discarded.
- fetch_en=0: fpc and storage hold; pops continue normally.
- out_valid = (count != 0). Head fields come from entry[rd_ptr], gated to 0 when the queue is empty.
- Storage contents are not reset. Only pointers, count and fpc are reset, and the output gating hides stale data.

## Timing
- Reset asserted, asynchronously:
  - fpc=0, count=0, pointers=0.
  - out_valid=0; out_inst, out_pc and out_pc4 are 0; imem_addr=0.
  - imem_req = fetch_en & ~redirect.
- Reset deasserted: the first push happens at the first rising edge with fetch_en=1.
- Latency from fetch to output is 1 cycle. An instruction pushed at edge N is visible on out_* after edge N. There is no empty-queue bypass.
- Redirect latency:
  - Redirect sampled at edge N.
  - Target fetched (pushed) at edge N+1.
  - out_valid=1 with out_pc = target after edge N+1.
- Handshake:
  - out_* stay stable while out_valid=1 and out_ready=0, unless redirect or Reset occurs.
  - out_ready may be asserted while out_valid=0; it has no effect.
- Sustained throughput is 1 instruction per cycle when out_ready is held at 1.
- Reset asserted mid-operation, including in the same cycle as redirect, push or pop, overrides every other input.

## Test plan
- Streaming: reset, fetch_en=1, out_ready=1, imem returns mem[addr>>2] -> out_pc = 0, 4, 8, 0xC on consecutive cycles starting one cycle after the first edge; count stays 1.
- Fill and stall: out_ready=0 for 6 cycles -> count reaches 4 and then holds; imem_req=0 while full; out_pc stays 0. Then out_ready=1 -> 0, 4, 8, 0xC, 0x10 appear in order, with no gap and no duplicate.
- Full with simultaneous pop: count=4, out_ready=1 -> push occurs; count stays 4; the pushed entry has pc 0x10.
- Redirect: redirect=1 with redirect_pc=0x43 while count=3 and out_ready=1 -> the next cycle shows count=0 and out_valid=0; one cycle later out_valid=1 with out_pc=0x40 and out_pc4=0x44.
- PC wrap: redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> successive out_pc values are 0xFFFF_FFFF_FFFF_FFFC, then 0x0, then 0x4.
- Reset mid-stream: assert Reset between edges with count=2 -> out_valid, count and imem_addr go to 0 before the next edge. After release, fetch restarts at pc 0.
